log_reader_out_ctrl_multi: RTL

Parametrised next-generation output controller for the VR log reader.
- Accepts a per-request command giving start entry address, entry count and framing mode.
- Streams the entry flits from the header/entry FIFO to the destination stream and drives the entry-read address.
- Tracks entry boundaries and the final entry internally with its own counter, so no external last-entry flag is needed.
- Sits between the log entry RAM read side / write-header FIFO and the outbound packet assembler.

---
 rtl/log_reader_out_pkg.sv | 19 +
 rtl/log_reader_out_ctrl_multi_ctrl.sv | 107 ++++++++++
 rtl/log_reader_out_ctrl_multi.sv | 104 ++++++++++
 3 files changed

// File: rtl/log_reader_out_pkg.sv
// log_reader_out_pkg
//   Shared types and default widths for the VR log reader output controller.
//   log_out_state_e : controller state (IDLE, ENTRIES_OUT, DONE)
//   LOG_DATA_W      : default entry flit width
//   LOG_ADDR_W      : default log entry address width (ring, wraps)
//   LOG_ENTRY_CNT_W : default width of the per-request entry count
package log_reader_out_pkg;

    localparam int LOG_DATA_W      = 512;
    localparam int LOG_ADDR_W      = 10;
    localparam int LOG_ENTRY_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ENTRIES_OUT = 2'd1,
        DONE        = 2'd2
    } log_out_state_e;

endpackage

// File: rtl/log_reader_out_ctrl_multi_ctrl.sv
// log_reader_out_ctrl_multi_ctrl
//   Request FSM, remaining-entry counter and output framing for the log
//   reader output controller. Flit handshakes are combinational pass-through
//   while streaming; cmd_rdy/output_done/req_done are registered.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   cmd_val               : request valid (accepted while idle)
//   cmd_num_entries       : entries to emit, 0 legal
//   cmd_per_entry_last    : frame every entry (1) or only the final one (0)
//   src_data_val/_last    : FIFO flit valid / last flit of entry
//   dst_rdy               : destination ready
//   cmd_rdy, output_done  : high while idle
//   req_done              : one-cycle pulse when a request completes
//   src_rdy, dst_data_val : handshake pass-through while streaming
//   dst_data_last         : framed last
//   cmd_accept            : request taken this cycle
//   entry_done            : final flit of an entry transfers this cycle
module log_reader_out_ctrl_multi_ctrl
    import log_reader_out_pkg::*;
#(
    parameter int ENTRY_CNT_W = LOG_ENTRY_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_val,
    input  logic [ENTRY_CNT_W-1:0] cmd_num_entries,
    input  logic                   cmd_per_entry_last,
    input  logic                   src_data_val,
    input  logic                   src_data_last,
    input  logic                   dst_rdy,
    output logic                   cmd_rdy,
    output logic                   output_done,
    output logic                   req_done,
    output logic                   src_rdy,
    output logic                   dst_data_val,
    output logic                   dst_data_last,
    output logic                   cmd_accept,
    output logic                   entry_done
);

    log_out_state_e         state;
    logic [ENTRY_CNT_W-1:0] remaining;
    logic                   mode;
    logic                   streaming;
    logic                   last_entry;

    always_comb begin
        streaming     = (state == ENTRIES_OUT);
        last_entry    = (remaining == ENTRY_CNT_W'(1));
        src_rdy       = streaming & dst_rdy;
        dst_data_val  = streaming & src_data_val;
        dst_data_last = streaming & src_data_last & (mode | last_entry);
        entry_done    = dst_data_val & dst_rdy & src_data_last;
        cmd_accept    = (state == IDLE) & cmd_val;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            remaining   <= '0;
            mode        <= 1'b0;
            cmd_rdy     <= 1'b1;
            output_done <= 1'b1;
            req_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_val) begin
                        remaining   <= cmd_num_entries;
                        mode        <= cmd_per_entry_last;
                        cmd_rdy     <= 1'b0;
                        output_done <= 1'b0;
                        // An empty request goes straight to completion.
                        if (cmd_num_entries == '0) begin
                            state    <= DONE;
                            req_done <= 1'b1;
                        end else begin
                            state <= ENTRIES_OUT;
                        end
                    end
                end
                ENTRIES_OUT: begin
                    if (entry_done) begin
                        remaining <= remaining - ENTRY_CNT_W'(1);
                        if (last_entry) begin
                            state    <= DONE;
                            req_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    req_done    <= 1'b0;
                    cmd_rdy     <= 1'b1;
                    output_done <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    req_done    <= 1'b0;
                    cmd_rdy     <= 1'b1;
                    output_done <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/log_reader_out_ctrl_multi.sv
// log_reader_out_ctrl_multi
//   Output controller for the VR log reader. Takes a request (start address,
//   entry count, framing mode), streams entry flits from the header/entry FIFO
//   to the outbound packet assembler and steps the entry-read address at each
//   entry boundary (ring address, wraps modulo 2^ADDR_W).
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   cmd_val/cmd_rdy            : request handshake
//   cmd_start_addr             : first entry address
//   cmd_num_entries            : entries to emit (0 legal)
//   cmd_per_entry_last         : 1 = dst last per entry, 0 = only final entry
//   src_data_val/src_data/src_data_last/src_rdy : FIFO side
//   dst_data_val/dst_data/dst_data_last/dst_rdy : destination side
//   entry_addr                 : registered entry read address
//   output_done                : high while idle
//   req_done                   : one-cycle completion pulse
// Optional (LOG_READER_OUT_STATS_EN defined):
//   stat_entries_out, stat_flits_out : free-running wrap-around counters
module log_reader_out_ctrl_multi
    import log_reader_out_pkg::*;
#(
    parameter int DATA_W      = LOG_DATA_W,
    parameter int ADDR_W      = LOG_ADDR_W,
    parameter int ENTRY_CNT_W = LOG_ENTRY_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_val,
    input  logic [ADDR_W-1:0]      cmd_start_addr,
    input  logic [ENTRY_CNT_W-1:0] cmd_num_entries,
    input  logic                   cmd_per_entry_last,
    output logic                   cmd_rdy,
    input  logic                   src_data_val,
    input  logic [DATA_W-1:0]      src_data,
    input  logic                   src_data_last,
    output logic                   src_rdy,
    output logic                   dst_data_val,
    output logic [DATA_W-1:0]      dst_data,
    output logic                   dst_data_last,
    input  logic                   dst_rdy,
    output logic [ADDR_W-1:0]      entry_addr,
    output logic                   output_done,
    output logic                   req_done
`ifdef LOG_READER_OUT_STATS_EN
    ,
    output logic [31:0]            stat_entries_out,
    output logic [31:0]            stat_flits_out
`endif
);

    logic cmd_accept;
    logic entry_done;

    log_reader_out_ctrl_multi_ctrl #(
        .ENTRY_CNT_W (ENTRY_CNT_W)
    ) u_ctrl (
        .clk                (clk),
        .rst_n              (rst_n),
        .cmd_val            (cmd_val),
        .cmd_num_entries    (cmd_num_entries),
        .cmd_per_entry_last (cmd_per_entry_last),
        .src_data_val       (src_data_val),
        .src_data_last      (src_data_last),
        .dst_rdy            (dst_rdy),
        .cmd_rdy            (cmd_rdy),
        .output_done        (output_done),
        .req_done           (req_done),
        .src_rdy            (src_rdy),
        .dst_data_val       (dst_data_val),
        .dst_data_last      (dst_data_last),
        .cmd_accept         (cmd_accept),
        .entry_done         (entry_done)
    );

    // Data is a straight wire; it is only meaningful while dst_data_val is high.
    assign dst_data = src_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry_addr <= '0;
        end else if (cmd_accept) begin
            entry_addr <= cmd_start_addr;
        end else if (entry_done) begin
            entry_addr <= entry_addr + ADDR_W'(1);
        end
    end

`ifdef LOG_READER_OUT_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_entries_out <= '0;
            stat_flits_out   <= '0;
        end else begin
            if (entry_done) begin
                stat_entries_out <= stat_entries_out + 32'd1;
            end
            if (dst_data_val & dst_rdy) begin
                stat_flits_out <= stat_flits_out + 32'd1;
            end
        end
    end
`endif

endmodule
